// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, shift-register geometry,
// bit-time defaults and the frame-length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    DATA    = 2'd2,
    DONE_ST = 2'd3
  } rx_state_t;

  localparam int Q_W          = 10;
  localparam int BAUD_W_DEF   = 19;
  localparam int MIN_BIT_TIME = 4;

  // Line-idle ones: unused LSBs of a short frame stay at 1.
  localparam logic [Q_W-1:0] RESET_Q_DEF = 10'h3FF;

  // Bits shifted after the start bit: 7 data + optional 8th + optional parity + stop.
  function automatic logic [3:0] frame_bits(input logic eight, input logic pen);
    return 4'd8 + {3'b000, eight} + {3'b000, pen};
  endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// Bundle between the serial line / configuration side and the receive engine.
// DONE is a valid-only strobe: it is high for exactly one clock when Q holds a
// complete frame; there is no ready, the consumer must take Q on that cycle or
// any later cycle before the next start bit (Q is held until then).
interface uart_rx_engine_if
  import uart_pkg::*;
#(
  parameter int BAUD_W = BAUD_W_DEF
);
  logic              RX;
  logic              EIGHT;
  logic              PEN;
  logic [BAUD_W-1:0] BAUD_K;
  logic [Q_W-1:0]    Q;
  logic              DONE;
  logic              BUSY;
  rx_state_t         dbg_state;

  modport master (
    output RX, EIGHT, PEN, BAUD_K,
    input  Q, DONE, BUSY, dbg_state
  );

  modport slave (
    input  RX, EIGHT, PEN, BAUD_K,
    output Q, DONE, BUSY, dbg_state
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-time tick counter shared by the receive and transmit engines.
// Counts while enabled, wraps at the full terminal count, and flags the
// half-bit and full-bit points of the programmed bit time k (k >= 4).
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BAUD_W = BAUD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [BAUD_W-1:0] k,
  output logic              half_tc,
  output logic              full_tc
);

  logic [BAUD_W-1:0] tick;
  logic [BAUD_W-1:0] half;

  assign half    = k >> 1;
  assign half_tc = (tick == half - BAUD_W'(1));
  assign full_tc = (tick == k - BAUD_W'(1));

  // Tick register: clear has priority over counting; wrap at k-1.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      tick <= '0;
    end else if (en) begin
      tick <= full_tc ? '0 : tick + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive bit engine: synchronises RX, qualifies the start bit at
// half-bit time, then samples each following bit at mid-bit and shifts it
// into Q from the top so the stop bit lands in Q[9].
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int             BAUD_W  = BAUD_W_DEF,
  parameter logic [Q_W-1:0] RESET_Q = RESET_Q_DEF
) (
  input logic             clk,
  input logic             reset,
  uart_rx_engine_if.slave bus
);

  logic              rx_meta;
  logic              rx_s;
  rx_state_t         state;
  rx_state_t         state_nxt;
  logic              eight_l;
  logic              pen_l;
  logic [BAUD_W-1:0] k_l;
  logic [BAUD_W-1:0] k_clamped;
  logic [3:0]        bit_cnt;
  logic [Q_W-1:0]    q_r;
  logic              half_tc;
  logic              full_tc;
  logic              tmr_clr;
  logic              tmr_en;
  logic              start_det;
  logic              start_ok;
  logic              shift_en;
  logic              last_shift;
  logic              busy;
  logic              done;

  assign k_clamped  = (bus.BAUD_K < BAUD_W'(MIN_BIT_TIME)) ? BAUD_W'(MIN_BIT_TIME) : bus.BAUD_K;
  assign start_det  = (state == IDLE) && !rx_s;
  assign start_ok   = (state == START) && half_tc && !rx_s;
  assign shift_en   = (state == DATA) && full_tc;
  assign last_shift = shift_en && ((bit_cnt + 4'd1) == frame_bits(eight_l, pen_l));

  // Timer restarts on entering START and again at the qualified start mid-point.
  assign tmr_clr = (state == IDLE) || ((state == START) && half_tc);
  assign tmr_en  = (state == START) || (state == DATA);

  uart_bit_timer #(.BAUD_W(BAUD_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .k       (k_l),
    .half_tc (half_tc),
    .full_tc (full_tc)
  );

  // Two-flop synchroniser on the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.RX;
      rx_s    <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: false starts return to IDLE, DONE_ST lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (half_tc) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (last_shift) state_nxt = DONE_ST;
      DONE_ST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE_ST);
  end

  // Frame datapath: latch config at start detect, shift on each bit sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r     <= RESET_Q;
      bit_cnt <= '0;
      eight_l <= 1'b0;
      pen_l   <= 1'b0;
      k_l     <= '0;
    end else begin
      if (start_det) begin
        q_r     <= RESET_Q;
        eight_l <= bus.EIGHT;
        pen_l   <= bus.PEN;
        k_l     <= k_clamped;
      end
      if (start_ok) begin
        bit_cnt <= '0;
      end
      if (shift_en) begin
        q_r     <= {rx_s, q_r[Q_W-1:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  assign bus.Q         = q_r;
  assign bus.DONE      = done;
  assign bus.BUSY      = busy;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: one task per scenario, inline checks,
// DONE events collected by a negedge monitor.
module tb_uart_rx_engine;
  import uart_pkg::*;

  logic clk;
  logic reset;
  int   cyc;
  int   pass_cnt;
  int   total_cnt;
  int   fall_cyc;
  int   busy_cnt;
  logic post_pending;

  logic [9:0] obs_q[$];
  int         obs_cyc_q[$];
  logic       post_busy_q[$];
  logic [9:0] exp_q[$];

  uart_rx_engine_if #(.BAUD_W(19)) bus ();

  uart_rx_engine #(.BAUD_W(19), .RESET_Q(10'h3FF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: record every DONE with its Q and cycle, and BUSY one cycle later
  always @(negedge clk) begin
    if (post_pending) begin
      post_busy_q.push_back(bus.BUSY);
      post_pending = 1'b0;
    end
    if (bus.DONE === 1'b1) begin
      obs_q.push_back(bus.Q);
      obs_cyc_q.push_back(cyc);
      post_pending = 1'b1;
    end
    if (bus.BUSY === 1'b1) busy_cnt++;
  end

  // driver: start bit then n bits LSB first, k clocks each; called at posedge+1
  task automatic drive_frame(input logic [9:0] bits, input int n, input int k);
    fall_cyc = cyc;
    bus.RX = 1'b0;
    repeat (k) @(posedge clk);
    for (int i = 0; i < n; i++) begin
      #1;
      bus.RX = bits[i];
      repeat (k) @(posedge clk);
    end
    #1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc_q.delete();
    post_busy_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.BUSY);
    else pass_cnt++;
    total_cnt++;
    if (bus.DONE !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.DONE);
    else pass_cnt++;
    total_cnt++;
    if (bus.Q !== 10'h3FF) $display("FAIL reset_q got=%h exp=3ff", bus.Q);
    else pass_cnt++;
    total_cnt++;
    if (bus.dbg_state !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, IDLE);
    else pass_cnt++;
  endtask

  task automatic test_8e1();
    logic [9:0] got;
    int lat;
    clear_obs();
    bus.EIGHT = 1'b1; bus.PEN = 1'b1; bus.BAUD_K = 19'd16;
    @(posedge clk); #1;
    drive_frame(10'h2A5, 10, 16);
    repeat (40) @(posedge clk);
    got = (obs_q.size() > 0) ? obs_q[0] : 10'hxxx;
    lat = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] - fall_cyc : -1;
    total_cnt++;
    if (obs_q.size() != 1) $display("FAIL 8e1_done_count got=%0d exp=1", obs_q.size());
    else pass_cnt++;
    total_cnt++;
    if (got !== 10'h2A5) $display("FAIL 8e1_q got=%h exp=2a5", got);
    else pass_cnt++;
    total_cnt++;
    if (lat != 171) $display("FAIL 8e1_latency got=%0d exp=171", lat);
    else pass_cnt++;
  endtask

  task automatic test_8n1();
    logic [9:0] got;
    clear_obs();
    bus.EIGHT = 1'b1; bus.PEN = 1'b0; bus.BAUD_K = 19'd16;
    @(posedge clk); #1;
    drive_frame(10'h13C, 9, 16);
    repeat (40) @(posedge clk);
    got = (obs_q.size() > 0) ? obs_q[0] : 10'hxxx;
    total_cnt++;
    if (obs_q.size() != 1) $display("FAIL 8n1_done_count got=%0d exp=1", obs_q.size());
    else pass_cnt++;
    total_cnt++;
    if (got !== 10'h279) $display("FAIL 8n1_q got=%h exp=279", got);
    else pass_cnt++;
    total_cnt++;
    if ((got >> 1) !== 10'h13C) $display("FAIL 8n1_justified got=%h exp=13c", got >> 1);
    else pass_cnt++;
  endtask

  task automatic test_7n1();
    logic [9:0] got;
    logic pb;
    int lat;
    clear_obs();
    bus.EIGHT = 1'b0; bus.PEN = 1'b0; bus.BAUD_K = 19'd16;
    @(posedge clk); #1;
    drive_frame(10'h0C1, 8, 16);
    repeat (40) @(posedge clk);
    got = (obs_q.size() > 0) ? obs_q[0] : 10'hxxx;
    lat = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] - fall_cyc : -1;
    pb  = (post_busy_q.size() > 0) ? post_busy_q[0] : 1'bx;
    total_cnt++;
    if (obs_q.size() != 1) $display("FAIL 7n1_done_count got=%0d exp=1", obs_q.size());
    else pass_cnt++;
    total_cnt++;
    if (got !== 10'h307) $display("FAIL 7n1_q got=%h exp=307", got);
    else pass_cnt++;
    total_cnt++;
    if (lat != 139) $display("FAIL 7n1_latency got=%0d exp=139", lat);
    else pass_cnt++;
    total_cnt++;
    if (pb !== 1'b0) $display("FAIL 7n1_busy_after_done got=%b exp=0", pb);
    else pass_cnt++;
  endtask

  task automatic test_false_start();
    int busy0;
    clear_obs();
    bus.EIGHT = 1'b1; bus.PEN = 1'b0; bus.BAUD_K = 19'd16;
    @(posedge clk); #1;
    busy0 = busy_cnt;
    bus.RX = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.RX = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (busy_cnt - busy0 != 8) $display("FAIL false_start_busy_len got=%0d exp=8", busy_cnt - busy0);
    else pass_cnt++;
    total_cnt++;
    if (obs_q.size() != 0) $display("FAIL false_start_no_done got=%0d exp=0", obs_q.size());
    else pass_cnt++;
    total_cnt++;
    if (bus.Q !== 10'h3FF) $display("FAIL false_start_q got=%h exp=3ff", bus.Q);
    else pass_cnt++;
    total_cnt++;
    if (bus.dbg_state !== IDLE) $display("FAIL false_start_state got=%0d exp=%0d", bus.dbg_state, IDLE);
    else pass_cnt++;
  endtask

  task automatic test_cfg_toggle();
    logic [9:0] got;
    clear_obs();
    bus.EIGHT = 1'b1; bus.PEN = 1'b1; bus.BAUD_K = 19'd16;
    @(posedge clk); #1;
    fork
      drive_frame(10'h2A5, 10, 16);
      begin
        repeat (50) @(posedge clk);
        #2;
        bus.EIGHT = 1'b0;
        bus.BAUD_K = 19'd8;
      end
    join
    repeat (40) @(posedge clk);
    bus.EIGHT = 1'b1; bus.BAUD_K = 19'd16;
    got = (obs_q.size() > 0) ? obs_q[0] : 10'hxxx;
    total_cnt++;
    if (obs_q.size() != 1) $display("FAIL cfg_toggle_done_count got=%0d exp=1", obs_q.size());
    else pass_cnt++;
    total_cnt++;
    if (got !== 10'h2A5) $display("FAIL cfg_toggle_q got=%h exp=2a5", got);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    clear_obs();
    bus.EIGHT = 1'b1; bus.PEN = 1'b0; bus.BAUD_K = 19'd16;
    @(posedge clk); #1;
    bus.RX = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      bus.RX = 1'b0;
      repeat (16) @(posedge clk);
    end
    #1;
    bus.RX = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.Q !== 10'h03F) $display("FAIL reset_mid_pre_q got=%h exp=03f", bus.Q);
    else pass_cnt++;
    total_cnt++;
    if (bus.BUSY !== 1'b1) $display("FAIL reset_mid_pre_busy got=%b exp=1", bus.BUSY);
    else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.BUSY !== 1'b0) $display("FAIL reset_mid_busy got=%b exp=0", bus.BUSY);
    else pass_cnt++;
    total_cnt++;
    if (bus.Q !== 10'h3FF) $display("FAIL reset_mid_q got=%h exp=3ff", bus.Q);
    else pass_cnt++;
    repeat (200) @(posedge clk);
    total_cnt++;
    if (obs_q.size() != 0) $display("FAIL reset_mid_no_done got=%0d exp=0", obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] got;
    int gap;
    clear_obs();
    exp_q.delete();
    bus.EIGHT = 1'b1; bus.PEN = 1'b0; bus.BAUD_K = 19'd16;
    exp_q.push_back(10'h279);
    exp_q.push_back(10'h387);
    @(posedge clk); #1;
    drive_frame(10'h13C, 9, 16);
    drive_frame(10'h1C3, 9, 16);
    repeat (40) @(posedge clk);
    total_cnt++;
    if (obs_q.size() != 2) $display("FAIL b2b_done_count got=%0d exp=2", obs_q.size());
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 10'hxxx;
      total_cnt++;
      if (got !== exp_q[i]) $display("FAIL b2b_q%0d got=%h exp=%h", i, got, exp_q[i]);
      else pass_cnt++;
    end
    gap = (obs_cyc_q.size() > 1) ? obs_cyc_q[1] - obs_cyc_q[0] : -1;
    total_cnt++;
    if (gap != 160) $display("FAIL b2b_done_gap got=%0d exp=160", gap);
    else pass_cnt++;
  endtask

  task automatic test_baud_clamp();
    logic [9:0] got;
    int lat;
    clear_obs();
    bus.EIGHT = 1'b1; bus.PEN = 1'b0; bus.BAUD_K = 19'd2;
    @(posedge clk); #1;
    drive_frame(10'h196, 9, 4);
    repeat (20) @(posedge clk);
    got = (obs_q.size() > 0) ? obs_q[0] : 10'hxxx;
    lat = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] - fall_cyc : -1;
    total_cnt++;
    if (obs_q.size() != 1) $display("FAIL clamp_done_count got=%0d exp=1", obs_q.size());
    else pass_cnt++;
    total_cnt++;
    if (got !== 10'h32D) $display("FAIL clamp_q got=%h exp=32d", got);
    else pass_cnt++;
    total_cnt++;
    if (lat != 41) $display("FAIL clamp_latency got=%0d exp=41", lat);
    else pass_cnt++;
  endtask

  initial begin
    cyc          = 0;
    pass_cnt     = 0;
    total_cnt    = 0;
    fall_cyc     = 0;
    busy_cnt     = 0;
    post_pending = 1'b0;
    reset        = 1'b1;
    bus.RX       = 1'b1;
    bus.EIGHT    = 1'b1;
    bus.PEN      = 1'b1;
    bus.BAUD_K   = 19'd16;
    test_reset();
    test_8e1();
    test_8n1();
    test_7n1();
    test_false_start();
    test_cfg_toggle();
    test_reset_mid();
    test_back_to_back();
    test_baud_clamp();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
